// File: rtl/rs_alu_dispatch.sv
// Reservation station in front of the integer ALU: holds issued ops, snoops the ALU/LSB
// result buses for pending operands, and dispatches the lowest-index ready op each cycle.
module rs_alu_dispatch #(
    parameter int unsigned RS_SIZE      = 16,
    parameter int unsigned OP_WIDTH     = 7,
    parameter int unsigned VAL_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned ROB_ID_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush,
    input  logic                    issue_valid,
    input  logic [OP_WIDTH-1:0]     issue_type,
    input  logic [VAL_WIDTH-1:0]    issue_vj,
    input  logic [VAL_WIDTH-1:0]    issue_vk,
    input  logic                    issue_qj_busy,
    input  logic                    issue_qk_busy,
    input  logic [ROB_ID_WIDTH:0]   issue_qj,
    input  logic [ROB_ID_WIDTH:0]   issue_qk,
    input  logic [ROB_ID_WIDTH:0]   issue_dest,
    input  logic [ADDR_WIDTH-1:0]   issue_pc,
    output logic                    rs_full,
    input  logic                    alu_ready,
    input  logic [ROB_ID_WIDTH:0]   alu_entry,
    input  logic [VAL_WIDTH-1:0]    alu_val,
    input  logic                    lsb_ready,
    input  logic [ROB_ID_WIDTH:0]   lsb_entry,
    input  logic [VAL_WIDTH-1:0]    lsb_val,
    output logic                    execute,
    output logic [OP_WIDTH-1:0]     op_type,
    output logic [VAL_WIDTH-1:0]    val1,
    output logic [VAL_WIDTH-1:0]    val2,
    output logic [ROB_ID_WIDTH:0]   entry,
    output logic [ADDR_WIDTH-1:0]   nowPC
);

    localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int unsigned TAG_W = ROB_ID_WIDTH + 1;

    // Entry state: control bits are reset, payload fields are only meaningful while busy.
    logic [RS_SIZE-1:0]                 busy;
    logic [RS_SIZE-1:0]                 rdy_j;
    logic [RS_SIZE-1:0]                 rdy_k;
    logic [RS_SIZE-1:0][OP_WIDTH-1:0]   e_type;
    logic [RS_SIZE-1:0][VAL_WIDTH-1:0]  e_vj;
    logic [RS_SIZE-1:0][VAL_WIDTH-1:0]  e_vk;
    logic [RS_SIZE-1:0][TAG_W-1:0]      e_qj;
    logic [RS_SIZE-1:0][TAG_W-1:0]      e_qk;
    logic [RS_SIZE-1:0][TAG_W-1:0]      e_dest;
    logic [RS_SIZE-1:0][ADDR_WIDTH-1:0] e_pc;

    logic                               sel_found;
    logic [IDX_W-1:0]                   sel_idx;
    logic                               free_found;
    logic [IDX_W-1:0]                   free_idx;
    logic                               do_issue;
    logic [RS_SIZE-1:0]                 sel_mask;
    logic [RS_SIZE-1:0]                 ins_mask;

    logic [RS_SIZE-1:0]                 wake_j;
    logic [RS_SIZE-1:0]                 wake_k;
    logic [RS_SIZE-1:0][VAL_WIDTH-1:0]  wake_vj;
    logic [RS_SIZE-1:0][VAL_WIDTH-1:0]  wake_vk;

    logic                               ins_rdy_j;
    logic                               ins_rdy_k;
    logic [VAL_WIDTH-1:0]               ins_vj;
    logic [VAL_WIDTH-1:0]               ins_vk;

    assign rs_full = &busy;

    // Priority pick of the lowest-index ready entry and the lowest-index free entry.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            if (busy[i] && rdy_j[i] && rdy_k[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign do_issue = issue_valid && free_found;
    assign sel_mask = sel_found ? (RS_SIZE'(1) << sel_idx)  : '0;
    assign ins_mask = do_issue  ? (RS_SIZE'(1) << free_idx) : '0;

    // Broadcast snoop for entries already in the station; the ALU bus takes precedence.
    always_comb begin
        logic hit_aj, hit_lj, hit_ak, hit_lk;
        hit_aj  = 1'b0;
        hit_lj  = 1'b0;
        hit_ak  = 1'b0;
        hit_lk  = 1'b0;
        wake_j  = '0;
        wake_k  = '0;
        wake_vj = '0;
        wake_vk = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            hit_aj     = alu_ready && (alu_entry == e_qj[i]);
            hit_lj     = lsb_ready && (lsb_entry == e_qj[i]);
            hit_ak     = alu_ready && (alu_entry == e_qk[i]);
            hit_lk     = lsb_ready && (lsb_entry == e_qk[i]);
            wake_j[i]  = busy[i] && !rdy_j[i] && (hit_aj || hit_lj);
            wake_k[i]  = busy[i] && !rdy_k[i] && (hit_ak || hit_lk);
            wake_vj[i] = hit_aj ? alu_val : lsb_val;
            wake_vk[i] = hit_ak ? alu_val : lsb_val;
        end
    end

    // Operand resolution for the op being inserted, including same-cycle broadcast bypass.
    always_comb begin
        ins_rdy_j = 1'b0;
        ins_vj    = issue_vj;
        if (!issue_qj_busy) begin
            ins_rdy_j = 1'b1;
        end else if (alu_ready && (alu_entry == issue_qj)) begin
            ins_rdy_j = 1'b1;
            ins_vj    = alu_val;
        end else if (lsb_ready && (lsb_entry == issue_qj)) begin
            ins_rdy_j = 1'b1;
            ins_vj    = lsb_val;
        end
    end

    always_comb begin
        ins_rdy_k = 1'b0;
        ins_vk    = issue_vk;
        if (!issue_qk_busy) begin
            ins_rdy_k = 1'b1;
        end else if (alu_ready && (alu_entry == issue_qk)) begin
            ins_rdy_k = 1'b1;
            ins_vk    = alu_val;
        end else if (lsb_ready && (lsb_entry == issue_qk)) begin
            ins_rdy_k = 1'b1;
            ins_vk    = lsb_val;
        end
    end

    // Occupancy, readiness and the registered dispatch port.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            busy    <= '0;
            rdy_j   <= '0;
            rdy_k   <= '0;
            execute <= 1'b0;
            op_type <= '0;
            val1    <= '0;
            val2    <= '0;
            entry   <= '0;
            nowPC   <= '0;
        end else if (flush) begin
            busy    <= '0;
            execute <= 1'b0;
        end else if (rdy_in) begin
            busy  <= (busy & ~sel_mask) | ins_mask;
            rdy_j <= rdy_j | wake_j;
            rdy_k <= rdy_k | wake_k;
            if (do_issue) begin
                rdy_j[free_idx] <= ins_rdy_j;
                rdy_k[free_idx] <= ins_rdy_k;
            end
            execute <= sel_found;
            if (sel_found) begin
                op_type <= e_type[sel_idx];
                val1    <= e_vj[sel_idx];
                val2    <= e_vk[sel_idx];
                entry   <= e_dest[sel_idx];
                nowPC   <= e_pc[sel_idx];
            end
        end
    end

    // Payload storage; a freshly inserted slot is never a wakeup target in the same cycle.
    always_ff @(posedge clk) begin
        if (rdy_in && !flush) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                if (wake_j[i]) e_vj[i] <= wake_vj[i];
                if (wake_k[i]) e_vk[i] <= wake_vk[i];
            end
            if (do_issue) begin
                e_type[free_idx] <= issue_type;
                e_vj[free_idx]   <= ins_vj;
                e_vk[free_idx]   <= ins_vk;
                e_qj[free_idx]   <= issue_qj;
                e_qk[free_idx]   <= issue_qk;
                e_dest[free_idx] <= issue_dest;
                e_pc[free_idx]   <= issue_pc;
            end
        end
    end

endmodule

// File: tb/tb_rs_alu_dispatch.sv
// Directed and randomized bench for rs_alu_dispatch against a slot-array reference model.
module tb_rs_alu_dispatch;

    localparam int RS = 16;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, flush;
    logic        issue_valid, issue_qj_busy, issue_qk_busy;
    logic [6:0]  issue_type;
    logic [31:0] issue_vj, issue_vk, issue_pc;
    logic [4:0]  issue_qj, issue_qk, issue_dest;
    logic        rs_full;
    logic        alu_ready, lsb_ready;
    logic [4:0]  alu_entry, lsb_entry;
    logic [31:0] alu_val, lsb_val;
    logic        execute;
    logic [6:0]  op_type;
    logic [31:0] val1, val2, nowPC;
    logic [4:0]  entry;

    always #5 clk = ~clk;

    rs_alu_dispatch dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .issue_valid(issue_valid), .issue_type(issue_type),
        .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
        .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_dest(issue_dest),
        .issue_pc(issue_pc), .rs_full(rs_full),
        .alu_ready(alu_ready), .alu_entry(alu_entry), .alu_val(alu_val),
        .lsb_ready(lsb_ready), .lsb_entry(lsb_entry), .lsb_val(lsb_val),
        .execute(execute), .op_type(op_type), .val1(val1), .val2(val2),
        .entry(entry), .nowPC(nowPC)
    );

    typedef struct {
        bit          busy;
        bit          rj;
        bit          rk;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [4:0]  tj;
        logic [4:0]  tk;
        logic [4:0]  dest;
        logic [6:0]  ty;
        logic [31:0] pc;
    } ent_t;

    ent_t        st[RS];
    logic        m_exec;
    logic [6:0]  m_type;
    logic [31:0] m_v1, m_v2, m_pc;
    logic [4:0]  m_entry;

    int checks = 0;
    int errors = 0;
    int consumed6 = 0;
    bit count_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_full();
        for (int i = 0; i < RS; i++) if (!st[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    // Value of an operand as seen on the broadcast buses this cycle (ALU first).
    task automatic snoop(input logic [4:0] tag, inout bit r, inout logic [31:0] v);
        if (alu_ready && alu_entry == tag) begin r = 1'b1; v = alu_val; end
        else if (lsb_ready && lsb_entry == tag) begin r = 1'b1; v = lsb_val; end
    endtask

    task automatic model_reset();
        for (int i = 0; i < RS; i++) st[i].busy = 1'b0;
        m_exec = 1'b0; m_type = '0; m_v1 = '0; m_v2 = '0; m_entry = '0; m_pc = '0;
    endtask

    task automatic model_step();
        int s, f;
        ent_t n;
        if (rst_in) begin
            model_reset();
        end else if (flush) begin
            for (int i = 0; i < RS; i++) st[i].busy = 1'b0;
            m_exec = 1'b0;
        end else if (rdy_in) begin
            s = -1; f = -1;
            for (int i = 0; i < RS; i++) begin
                if (s < 0 && st[i].busy && st[i].rj && st[i].rk) s = i;
                if (f < 0 && !st[i].busy) f = i;
            end
            for (int i = 0; i < RS; i++) begin
                if (st[i].busy && !st[i].rj) snoop(st[i].tj, st[i].rj, st[i].vj);
                if (st[i].busy && !st[i].rk) snoop(st[i].tk, st[i].rk, st[i].vk);
            end
            m_exec = (s >= 0);
            if (s >= 0) begin
                m_type = st[s].ty; m_v1 = st[s].vj; m_v2 = st[s].vk;
                m_entry = st[s].dest; m_pc = st[s].pc;
                st[s].busy = 1'b0;
            end
            if (issue_valid && f >= 0) begin
                n.busy = 1'b1; n.ty = issue_type; n.dest = issue_dest; n.pc = issue_pc;
                n.tj = issue_qj; n.tk = issue_qk; n.vj = issue_vj; n.vk = issue_vk;
                n.rj = !issue_qj_busy; n.rk = !issue_qk_busy;
                if (!n.rj) snoop(n.tj, n.rj, n.vj);
                if (!n.rk) snoop(n.tk, n.rk, n.vk);
                st[f] = n;
            end
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, "_execute"}, 64'(execute), 64'(m_exec));
        chk({ph, "_type"},    64'(op_type), 64'(m_type));
        chk({ph, "_val1"},    64'(val1),    64'(m_v1));
        chk({ph, "_val2"},    64'(val2),    64'(m_v2));
        chk({ph, "_entry"},   64'(entry),   64'(m_entry));
        chk({ph, "_nowPC"},   64'(nowPC),   64'(m_pc));
        chk({ph, "_rs_full"}, 64'(rs_full), 64'(m_full()));
    endtask

    task automatic tick(input string ph);
        if (count_en && rdy_in && !rst_in && execute === 1'b1 && entry == 5'd6) consumed6++;
        model_step();
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; alu_ready = 1'b0; lsb_ready = 1'b0;
        flush = 1'b0; rdy_in = 1'b1;
    endtask

    task automatic set_issue(input logic [6:0] ty, input logic [31:0] vj, input logic [31:0] vk,
                             input bit qjb, input logic [4:0] qj, input bit qkb,
                             input logic [4:0] qk, input logic [4:0] dest, input logic [31:0] pc);
        issue_valid = 1'b1; issue_type = ty; issue_vj = vj; issue_vk = vk;
        issue_qj_busy = qjb; issue_qj = qj; issue_qk_busy = qkb; issue_qk = qk;
        issue_dest = dest; issue_pc = pc;
    endtask

    initial begin
        rst_in = 1'b1;
        idle_inputs();
        set_issue(7'd0, 0, 0, 1'b0, 0, 1'b0, 0, 0, 0);
        issue_valid = 1'b0;
        alu_entry = '0; alu_val = '0; lsb_entry = '0; lsb_val = '0;
        model_reset();
        #2;
        check_all("por");
        tick("por");
        rst_in = 1'b0;
        tick("por");

        // Ready op dispatches one cycle after issue, exactly one pulse.
        set_issue(7'b0010000, 32'd5, 32'd7, 1'b0, 0, 1'b0, 0, 5'd3, 32'h100);
        tick("addi_ins");
        chk("addi_no_early", 64'(execute), 64'd0);
        idle_inputs();
        tick("addi_disp");
        chk("addi_exec", 64'(execute), 64'd1);
        chk("addi_val1", 64'(val1), 64'd5);
        chk("addi_val2", 64'(val2), 64'd7);
        chk("addi_entry", 64'(entry), 64'd3);
        tick("addi_after");
        chk("addi_one_pulse", 64'(execute), 64'd0);

        // Wakeup by ALU broadcast, then insert-cycle bypass.
        set_issue(7'b0110001, 32'hdead, 32'd1, 1'b1, 5'd9, 1'b0, 0, 5'd4, 32'h200);
        tick("wk_ins");
        idle_inputs();
        alu_ready = 1'b1; alu_entry = 5'd9; alu_val = 32'h10;
        tick("wk_bcast");
        chk("wk_not_yet", 64'(execute), 64'd0);
        idle_inputs();
        tick("wk_disp");
        chk("wk_exec", 64'(execute), 64'd1);
        chk("wk_val1", 64'(val1), 64'h10);
        set_issue(7'b0110010, 32'hbeef, 32'd2, 1'b1, 5'd9, 1'b0, 0, 5'd5, 32'h204);
        alu_ready = 1'b1; alu_entry = 5'd9; alu_val = 32'h20;
        lsb_ready = 1'b1; lsb_entry = 5'd9; lsb_val = 32'h99;
        tick("byp_ins");
        idle_inputs();
        tick("byp_disp");
        chk("byp_exec", 64'(execute), 64'd1);
        chk("byp_val1_alu_wins", 64'(val1), 64'h20);
        chk("byp_entry", 64'(entry), 64'd5);

        // Asynchronous reset with five pending entries.
        for (int i = 0; i < 5; i++) begin
            set_issue(7'd1, 32'(i), 32'd0, 1'b1, 5'd31, 1'b0, 0, 5'(i + 10), 32'h300);
            tick("pre_rst");
        end
        idle_inputs();
        rst_in = 1'b1;
        #1;
        model_reset();
        chk("rst_async_exec", 64'(execute), 64'd0);
        chk("rst_async_val1", 64'(val1), 64'd0);
        chk("rst_async_pc", 64'(nowPC), 64'd0);
        chk("rst_async_full", 64'(rs_full), 64'd0);
        tick("rst_hold");
        rst_in = 1'b0;
        lsb_ready = 1'b1; lsb_entry = 5'd31; lsb_val = 32'h77;
        tick("rst_bcast");
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick("rst_after");
            chk("rst_no_dispatch", 64'(execute), 64'd0);
        end

        // Fill all entries on tag 2, then release them with one LSB broadcast.
        for (int i = 0; i < RS; i++) begin
            set_issue(7'd2, 32'hface, 32'(i), 1'b1, 5'd2, 1'b0, 0, 5'(i), 32'(i * 4));
            tick("fill");
        end
        idle_inputs();
        chk("fill_full", 64'(rs_full), 64'd1);
        lsb_ready = 1'b1; lsb_entry = 5'd2; lsb_val = 32'habc;
        tick("fill_bcast");
        idle_inputs();
        for (int k = 0; k < RS; k++) begin
            tick("drain");
            chk("drain_exec", 64'(execute), 64'd1);
            chk("drain_order", 64'(entry), 64'(k));
            chk("drain_val1", 64'(val1), 64'habc);
            if (k == 0) chk("drain_full_drop", 64'(rs_full), 64'd0);
        end
        tick("drain_end");
        chk("drain_done", 64'(execute), 64'd0);

        // Flush with three busy entries and a concurrent issue.
        set_issue(7'd3, 32'd1, 32'd1, 1'b0, 0, 1'b0, 0, 5'd20, 32'h400);
        tick("fl_ready");
        for (int i = 0; i < 3; i++) begin
            set_issue(7'd3, 32'd0, 32'd0, 1'b1, 5'd30, 1'b0, 0, 5'(21 + i), 32'h404);
            tick("fl_busy");
        end
        set_issue(7'd3, 32'd9, 32'd9, 1'b0, 0, 1'b0, 0, 5'd25, 32'h410);
        flush = 1'b1;
        tick("fl_edge");
        chk("flush_exec", 64'(execute), 64'd0);
        chk("flush_full", 64'(rs_full), 64'd0);
        idle_inputs();
        alu_ready = 1'b1; alu_entry = 5'd30; alu_val = 32'h5;
        tick("fl_bcast");
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick("fl_after");
            chk("flush_no_dispatch", 64'(execute), 64'd0);
        end

        // Stall: dispatched tag 6 held stable and consumed once; wakeups ignored.
        set_issue(7'd4, 32'd0, 32'd0, 1'b1, 5'd12, 1'b0, 0, 5'd9, 32'h500);
        tick("st_pend");
        set_issue(7'd5, 32'h66, 32'h67, 1'b0, 0, 1'b0, 0, 5'd6, 32'h600);
        tick("st_ins");
        idle_inputs();
        count_en = 1'b1;
        tick("st_disp");
        chk("stall_disp", 64'(entry), 64'd6);
        rdy_in = 1'b0;
        alu_ready = 1'b1; alu_entry = 5'd12; alu_val = 32'h12;
        for (int i = 0; i < 4; i++) begin
            tick("stall");
            chk("stall_exec", 64'(execute), 64'd1);
            chk("stall_entry", 64'(entry), 64'd6);
            chk("stall_pc", 64'(nowPC), 64'h600);
        end
        idle_inputs();
        tick("st_resume");
        chk("stall_wake_ignored", 64'(execute), 64'd0);
        tick("st_resume2");
        count_en = 1'b0;
        chk("stall_consumed_once", 64'(consumed6), 64'd1);
        alu_ready = 1'b1; alu_entry = 5'd12; alu_val = 32'h34;
        tick("st_wake");
        idle_inputs();
        tick("st_wake_disp");
        chk("stall_late_wake", 64'(entry), 64'd9);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 800; c++) begin
            rdy_in = ($urandom % 8) != 0;
            flush = ($urandom % 60) == 0;
            alu_ready = ($urandom % 3) == 0;
            alu_entry = 5'($urandom % 8);
            alu_val = $urandom;
            lsb_ready = ($urandom % 4) == 0;
            lsb_entry = 5'($urandom % 8);
            lsb_val = $urandom;
            set_issue(7'($urandom), $urandom, $urandom, 1'($urandom), 5'($urandom % 8),
                      1'($urandom), 5'($urandom % 8), 5'($urandom), $urandom);
            issue_valid = (($urandom % 3) != 0) && !m_full();
            tick("rand");
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
